// File: rtl/bce_column_mac_if.sv
// Group-load, column-offset and result signals between bce_column_mac and
// its driver (the zero-column index processor plus the group source).
interface bce_column_mac_if #(
  parameter int N     = 8,
  parameter int ACT_W = 8,
  parameter int ACC_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic [8*N-1:0]          weights;
  logic [ACT_W*N-1:0]      acts;
  logic [6:0]              index_vector;
  logic [2:0]              shift_offset;
  logic                    offset_valid;
  logic                    offset_done;
  logic signed [ACC_W-1:0] result;
  logic                    out_valid;
  logic                    busy;
  logic                    err;

  modport master (
    output in_valid, weights, acts, shift_offset, offset_valid, offset_done,
    input  in_ready, index_vector, result, out_valid, busy, err
  );

  modport slave (
    input  in_valid, weights, acts, shift_offset, offset_valid, offset_done,
    output in_ready, index_vector, result, out_valid, busy, err
  );
endinterface

// File: rtl/bce_column_mac.sv
// Bit-column dot-product engine: latches one weight/activation group and
// accumulates one shifted column partial sum per offset from the index processor.
module bce_column_mac #(
  parameter int N      = 8,
  parameter int ACT_W  = 8,
  parameter int ACC_W  = 24,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rstn,
  bce_column_mac_if.slave  bus
);

  localparam int PSUM_W = ACT_W + 1 + $clog2(N);
  localparam int CNT_W  = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  state_e                  state_r;
  logic [7:0]              w_r   [N];
  logic [ACT_W-1:0]        act_r [N];
  logic [6:0]              idx_r;
  logic [6:0]              consumed_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] result_r;
  logic                    out_valid_r;
  logic                    err_r;
  logic [CNT_W-1:0]        cnt_r;

  logic [6:0]               mag_or_s;
  logic [6:0]               col_hot_s;
  logic signed [ACT_W:0]    act_ext_s;
  logic signed [ACT_W:0]    term_s;
  logic signed [PSUM_W-1:0] psum_s;
  logic signed [ACC_W-1:0]  part_ext_s;
  logic signed [ACC_W-1:0]  acc_next_s;

  assign bus.in_ready     = (state_r == ST_IDLE);
  assign bus.busy         = (state_r != ST_IDLE);
  assign bus.index_vector = idx_r;
  assign bus.result       = result_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.err          = err_r;

  // Non-zero column map of the group currently on the load bus
  always_comb begin
    mag_or_s = 7'd0;
    for (int i = 0; i < N; i++) begin
      mag_or_s = mag_or_s | bus.weights[8*i +: 7];
    end
  end

  // One-hot column select; offset 7 maps to no column at all
  always_comb begin
    case (bus.shift_offset)
      3'd0:    col_hot_s = 7'b0000001;
      3'd1:    col_hot_s = 7'b0000010;
      3'd2:    col_hot_s = 7'b0000100;
      3'd3:    col_hot_s = 7'b0001000;
      3'd4:    col_hot_s = 7'b0010000;
      3'd5:    col_hot_s = 7'b0100000;
      3'd6:    col_hot_s = 7'b1000000;
      default: col_hot_s = 7'b0000000;
    endcase
  end

  // Signed column partial sum; negation at ACT_W+1 bits keeps -2^(ACT_W-1) exact
  always_comb begin
    psum_s    = '0;
    act_ext_s = '0;
    term_s    = '0;
    for (int i = 0; i < N; i++) begin
      act_ext_s = {act_r[i][ACT_W-1], act_r[i]};
      if ((w_r[i][6:0] & col_hot_s) != 7'd0) begin
        if (w_r[i][7]) begin
          term_s = -act_ext_s;
        end else begin
          term_s = act_ext_s;
        end
      end else begin
        term_s = '0;
      end
      psum_s = psum_s + {{(PSUM_W-ACT_W-1){term_s[ACT_W]}}, term_s};
    end
    part_ext_s = {{(ACC_W-PSUM_W){psum_s[PSUM_W-1]}}, psum_s};
    acc_next_s = acc_r + (part_ext_s <<< bus.shift_offset);
  end

  // Group FSM with operand capture, accumulation and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      idx_r       <= 7'd0;
      consumed_r  <= 7'd0;
      acc_r       <= '0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= '0;
      for (int i = 0; i < N; i++) begin
        w_r[i]   <= 8'd0;
        act_r[i] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N; i++) begin
              w_r[i]   <= bus.weights[8*i +: 8];
              act_r[i] <= bus.acts[ACT_W*i +: ACT_W];
            end
            idx_r      <= mag_or_s;
            consumed_r <= 7'd0;
            acc_r      <= '0;
            err_r      <= 1'b0;
            cnt_r      <= CNT_W'(SETTLE);
            state_r    <= (mag_or_s == 7'd0) ? ST_OUT : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r <= CNT_W'(1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.offset_valid) begin
            if (bus.offset_done) begin
              state_r <= ST_OUT;
            end else if ((col_hot_s == 7'd0) || ((consumed_r & col_hot_s) != 7'd0)) begin
              state_r <= ST_RUN;
            end else if ((idx_r & col_hot_s) == 7'd0) begin
              err_r <= 1'b1;
            end else begin
              acc_r      <= acc_next_s;
              consumed_r <= consumed_r | col_hot_s;
              if ((consumed_r | col_hot_s) == idx_r) begin
                state_r <= ST_OUT;
              end
            end
          end
        end
        ST_OUT: begin
          result_r    <= acc_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
